bnn_weight_loader: RTL and testbench
====================================

Name: bnn_weight_loader

Overview:
Upstream feeder for the 8-8-4 BNN weight-load port. Accepts whole 8-bit neuron weight bytes over a valid/ready stream and buffers them in a small FIFO. Serialises each byte into the BNN's two-cycle nibble protocol: low nibble first, then high nibble, with load_en high on both cycles. Counts neurons loaded and flags completion after NUM_NEURONS bytes.

Parameters:
NUM_NEURONS, 12, weight bytes per load session (8 layer-1 + 4 layer-2)
FIFO_DEPTH, 4, byte FIFO entries (power of two, >=2)
IDX_W, 5, width of neuron index counter (must hold NUM_NEURONS)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
ena  input  1  global enable; when low, the block freezes all state and drives load_en=0
start  input  1  one-cycle pulse; opens a load session from IDLE or DONE
abort  input  1  one-cycle pulse; ends the session and flushes the FIFO
in_data  input  8  weight byte; bit7..bit0 map to neuron weight bits 7..0
in_valid  input  1  in_data valid
in_ready  output  1  byte accepted on an edge where in_valid && in_ready && ena
load_nibble  output  4  nibble to BNN weight port (uio_in[7:4])
load_en  output  1  load strobe to BNN (uio_in[3])
neuron_idx  output  IDX_W  count of neurons fully issued (0..NUM_NEURONS)
busy  output  1  session active (LOAD_LO or LOAD_HI)
done  output  1  all NUM_NEURONS bytes issued; sticky until start, abort or reset

Behaviour:
- Reset (asynchronous): state=IDLE; FIFO empty; accepted count=0; neuron_idx=0; load_nibble=0; load_en=0; in_ready=0; busy=0; done=0.
- All outputs are registered except in_ready.
- States: IDLE, LOAD_LO, LOAD_HI, DONE.
- IDLE: in_ready=0. start -> LOAD_LO, which clears accepted count, neuron_idx and done.
- DONE: done=1. start -> LOAD_LO with the same clears as from IDLE.
- in_ready = ena && busy && !fifo_full && (accepted < NUM_NEURONS). There is no bypass on a simultaneous push and pop while full; in_ready stays 0 that cycle.
- LOAD_LO with FIFO non-empty and ena:
  - Register load_nibble=head[3:0] and load_en=1.
  - Next state is LOAD_HI.
- LOAD_LO with FIFO empty: load_en=0 and the state is held.
- LOAD_HI with ena:
  - Register load_nibble=head[7:4] and load_en=1.
  - Pop the FIFO and increment neuron_idx.
  - If neuron_idx+1 == NUM_NEURONS, go to DONE; otherwise go to LOAD_LO.
- LOAD_HI is never left without issuing the high nibble, except on abort or reset.
- Nibbles always leave as pairs. The downstream bit_index toggles only on load_en, so a lone nibble would desynchronise it.
- Latency:
  - A byte accepted at edge E0 into an empty FIFO is issued with load_en=1 and the low nibble after edge E1.
  - The high nibble follows after edge E2.
  - Back-to-back bytes give continuous load_en=1 with alternating lo/hi nibbles, 2 cycles per byte.
- done rises at the same edge that registers the final high nibble. Hence done=1 and the final load_en=1 are visible in the same cycle, and load_en=0 from the next cycle.
- ena low: all registers hold, load_en is forced to 0, in_ready=0. When ena returns, the block resumes in the same state with the same head byte.
- abort in any state:
  - Go to IDLE and flush the FIFO.
  - Set load_en=0 and done=0; neuron_idx holds its value.
  - An abort in LOAD_HI leaves the downstream BNN mid-pair; recovery requires a BNN reset. Documented limitation.
- start and abort on the same edge: abort wins.
- start while busy: ignored.
- The byte counter saturates at NUM_NEURONS. No further bytes are accepted in the session.

Test Plan:
- start, then a single byte 0xA5 -> load_en=1 with nibble 0x5 after E1, nibble 0xA after E2, then load_en=0; neuron_idx=1; busy=1.
- start, 12 bytes 0x00..0x0B with in_valid held -> in_ready drops after the 12th accept; 24 consecutive load_en cycles with nibble sequence 0,0,1,0,...,B,0; done=1 on the last load_en cycle; neuron_idx=12; state DONE.
- Downstream check: drive the BNN with this block after its reset, load 12 bytes 0xFF -> every BNN weight register reads 0xFF.
- Stall in_valid so the FIFO fills (4 bytes, no pops while ena=0) -> in_ready=0, no byte lost. Release ena -> bytes issue in order.
- ena low in LOAD_HI -> load_en=0 and state held. ena high -> high nibble issued and neuron_idx increments once.
- abort after 3 bytes, then start and 12 new bytes -> FIFO flushed (no stale byte emitted), neuron_idx restarts at 0, done after 12. Also: asynchronous reset mid-pair -> all outputs 0 immediately.

Source files
------------

// File: rtl/bnn_weight_loader_if.sv
// bnn_weight_loader_if: valid/ready byte stream feeding the weight loader
interface bnn_weight_loader_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  modport master (output data, valid, input ready);
  modport slave  (input data, valid, output ready);
endinterface

// File: rtl/bnn_weight_loader.sv
// bnn_weight_loader: buffers weight bytes and issues them as lo/hi nibble pairs to the BNN
module bnn_weight_loader #(
  parameter int NUM_NEURONS = 12,
  parameter int FIFO_DEPTH  = 4,
  parameter int IDX_W       = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ena,
  input  logic                 start,
  input  logic                 abort,
  bnn_weight_loader_if.slave   stream,
  output logic [3:0]           load_nibble,
  output logic                 load_en,
  output logic [IDX_W-1:0]     neuron_idx,
  output logic                 busy,
  output logic                 done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [IDX_W-1:0] NUM  = IDX_W'(NUM_NEURONS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);
  typedef enum logic [1:0] {IDLE, LOAD_LO, LOAD_HI, DONE} state_t;
  state_t           state;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [IDX_W-1:0] accepted;
  logic             full, empty, push;
  logic [7:0]       head;
  assign full         = (wr_ptr - rd_ptr) == PW'(FIFO_DEPTH);
  assign empty        = wr_ptr == rd_ptr;
  assign head         = mem[rd_ptr[AW-1:0]];
  assign stream.ready = ena && busy && !full && (accepted < NUM);
  assign push         = stream.valid && stream.ready && !abort;
  // FIFO storage needs no reset; occupancy lives in the pointers
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= stream.data;
  // session FSM: pointers, counters and registered nibble outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      accepted    <= '0;
      neuron_idx  <= '0;
      load_nibble <= '0;
      load_en     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (!ena) begin
      load_en <= 1'b0;
    end else if (abort) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      load_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PW'(1);
        accepted <= accepted + IDX_W'(1);
      end
      case (state)
        LOAD_LO: begin
          load_en <= !empty;
          if (!empty) begin
            load_nibble <= head[3:0];
            state       <= LOAD_HI;
          end
        end
        LOAD_HI: begin
          load_nibble <= head[7:4];
          load_en     <= 1'b1;
          rd_ptr      <= rd_ptr + PW'(1);
          neuron_idx  <= neuron_idx + IDX_W'(1);
          state       <= (neuron_idx == LAST) ? DONE : LOAD_LO;
          busy        <= neuron_idx != LAST;
          done        <= neuron_idx == LAST;
        end
        default: begin
          load_en <= 1'b0;
          if (start) begin
            state      <= LOAD_LO;
            accepted   <= '0;
            neuron_idx <= '0;
            done       <= 1'b0;
            busy       <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bnn_weight_loader.sv
// tb_bnn_weight_loader: directed vector and sequence checks of the weight loader
module tb_bnn_weight_loader;
  logic       clk = 1'b0;
  logic       reset, ena, start, abort;
  logic [3:0] load_nibble;
  logic       load_en;
  logic [4:0] neuron_idx;
  logic       busy, done;
  bnn_weight_loader_if bus();
  bnn_weight_loader dut (
    .clk(clk), .reset(reset), .ena(ena), .start(start), .abort(abort),
    .stream(bus), .load_nibble(load_nibble), .load_en(load_en),
    .neuron_idx(neuron_idx), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_pass = 0;
  int base_i;
  // downstream model: pairs lo/hi nibbles into bytes on load_en, as the BNN does
  logic [7:0] cap_q[$];
  logic [3:0] cap_lo = 4'h0;
  logic       cap_half = 1'b0;
  always @(posedge clk)
    if (load_en) begin
      if (!cap_half) cap_lo = load_nibble;
      else cap_q.push_back({load_nibble, cap_lo});
      cap_half = !cap_half;
    end
  typedef struct {
    logic       start, abort, valid;
    logic [7:0] data;
    logic       en;
    logic [3:0] nib;
    int         idx;
    logic       busy, done, rdy;
  } vec_t;
  vec_t vt[6];
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_session(input logic [7:0] base, input logic inc, input logic stall);
    int   n_acc, en_cnt, first, last, b0;
    logic acc, fin, full_seen;
    b0 = cap_q.size(); n_acc = 0; en_cnt = 0; first = -1; last = -1; fin = 0; full_seen = 0;
    start = 1; tick; start = 0;
    chk("start_idx", neuron_idx, 0);
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    bus.valid = 1; bus.data = base;
    for (int c = 0; c < 200 && !fin; c++) begin
      if (stall) ena = !(c >= 10 && c < 14);
      #1;
      acc = bus.valid && bus.ready;
      if (!ena && c == 12) begin
        chk("stall_rdy", bus.ready, 0);
        chk("stall_en", load_en, 0);
      end
      if (bus.valid && !bus.ready && ena && n_acc < 12) full_seen = 1;
      @(posedge clk); #1;
      if (acc) begin
        n_acc++;
        bus.data = inc ? base + 8'(n_acc) : base;
        if (n_acc == 12) chk("sat_rdy", bus.ready, 0);
      end
      if (load_en) begin
        en_cnt++;
        if (first < 0) first = c;
        last = c;
      end
      if (done) begin
        fin = 1;
        chk("done_en", load_en, 1);
        chk("done_idx", neuron_idx, 12);
        chk("done_nib", load_nibble, (inc ? base + 11 : base) >> 4);
      end
    end
    chk("session_end", fin, 1);
    if (!stall) chk("en_contig", last - first + 1, 24);
    chk("en_count", en_cnt, 24);
    bus.valid = 0; tick;
    chk("post_en", load_en, 0);
    chk("post_done", done, 1);
    chk("post_busy", busy, 0);
    chk("post_rdy", bus.ready, 0);
    chk("byte_count", cap_q.size() - b0, 12);
    for (int i = 0; i < 12 && b0 + i < cap_q.size(); i++)
      chk($sformatf("byte%0d", i), cap_q[b0 + i], inc ? base + i : base);
    chk("full_seen", full_seen, 1);
  endtask
  initial begin
    reset = 1; ena = 1; start = 0; abort = 0; bus.valid = 0; bus.data = 8'h00;
    // start, A5 accepted, lo nibble after E1, hi after E2, idle, then abort
    vt[0] = '{1, 0, 0, 8'h00, 0, 4'h0, 0, 1, 0, 1};
    vt[1] = '{0, 0, 1, 8'hA5, 0, 4'h0, 0, 1, 0, 1};
    vt[2] = '{0, 0, 0, 8'h00, 1, 4'h5, 0, 1, 0, 1};
    vt[3] = '{0, 0, 0, 8'h00, 1, 4'hA, 1, 1, 0, 1};
    vt[4] = '{0, 0, 0, 8'h00, 0, 4'h0, 1, 1, 0, 1};
    vt[5] = '{0, 1, 0, 8'h00, 0, 4'h0, 1, 0, 0, 0};
    repeat (2) tick;
    chk("rst_nib", load_nibble, 0);
    chk("rst_en", load_en, 0);
    chk("rst_idx", neuron_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdy", bus.ready, 0);
    reset = 0; tick;
    for (int i = 0; i < 6; i++) begin
      start = vt[i].start; abort = vt[i].abort; bus.valid = vt[i].valid; bus.data = vt[i].data;
      tick;
      chk($sformatf("vec%0d_en", i), load_en, vt[i].en);
      if (vt[i].en) chk($sformatf("vec%0d_nib", i), load_nibble, vt[i].nib);
      chk($sformatf("vec%0d_idx", i), neuron_idx, vt[i].idx);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].busy);
      chk($sformatf("vec%0d_done", i), done, vt[i].done);
      chk($sformatf("vec%0d_rdy", i), bus.ready, vt[i].rdy);
    end
    start = 0; abort = 0; bus.valid = 0;
    run_session(8'h00, 1, 0);
    run_session(8'hFF, 0, 0);
    run_session(8'h10, 1, 1);
    // ena low while in LOAD_HI holds the pair open
    base_i = cap_q.size();
    start = 1; tick; start = 0;
    bus.valid = 1; bus.data = 8'h3C; tick; bus.valid = 0;
    tick;
    chk("hold_lo_en", load_en, 1);
    chk("hold_lo_nib", load_nibble, 4'hC);
    ena = 0; tick;
    chk("hold_en", load_en, 0);
    chk("hold_idx", neuron_idx, 0);
    tick;
    chk("hold_en2", load_en, 0);
    chk("hold_rdy", bus.ready, 0);
    ena = 1; tick;
    chk("hold_hi_en", load_en, 1);
    chk("hold_hi_nib", load_nibble, 4'h3);
    chk("hold_hi_idx", neuron_idx, 1);
    tick;
    chk("hold_after_en", load_en, 0);
    chk("hold_after_idx", neuron_idx, 1);
    chk("hold_bytes", cap_q.size() - base_i, 1);
    if (cap_q.size() > base_i) chk("hold_byte", cap_q[base_i], 8'h3C);
    // abort, simultaneous start+abort, then abort after three bytes
    abort = 1; tick; abort = 0;
    chk("abort_busy", busy, 0);
    start = 1; abort = 1; tick; start = 0; abort = 0;
    chk("sa_busy", busy, 0);
    chk("sa_rdy", bus.ready, 0);
    start = 1; tick; start = 0;
    chk("restart_idx", neuron_idx, 0);
    base_i = cap_q.size();
    bus.valid = 1; bus.data = 8'h50; tick;
    bus.data = 8'h51; tick;
    chk("ab_lo_en", load_en, 1);
    chk("ab_lo_nib", load_nibble, 4'h0);
    bus.data = 8'h52; tick;
    chk("ab_hi_nib", load_nibble, 4'h5);
    chk("ab_hi_idx", neuron_idx, 1);
    bus.valid = 0; abort = 1; tick; abort = 0;
    chk("ab_busy", busy, 0);
    chk("ab_en", load_en, 0);
    chk("ab_done", done, 0);
    chk("ab_idx", neuron_idx, 1);
    chk("ab_rdy", bus.ready, 0);
    tick;
    chk("ab_bytes", cap_q.size() - base_i, 1);
    if (cap_q.size() > base_i) chk("ab_byte", cap_q[base_i], 8'h50);
    run_session(8'h60, 1, 0);
    // asynchronous reset in the middle of a pair
    start = 1; tick; start = 0;
    bus.valid = 1; bus.data = 8'h9E; tick; bus.valid = 0;
    tick;
    chk("ar_lo_en", load_en, 1);
    chk("ar_lo_nib", load_nibble, 4'hE);
    #2 reset = 1;
    #1;
    chk("ar_nib", load_nibble, 0);
    chk("ar_en", load_en, 0);
    chk("ar_idx", neuron_idx, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_rdy", bus.ready, 0);
    tick; reset = 0; tick;
    chk("ar_after_busy", busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
